// File: rtl/shift_job_sched.sv
// shift_job_sched
// Two-requester job scheduler and sequencer for a WIDTH-bit bidirectional
// shift register. A job (load word, direction, fill bit, shift count) is
// accepted from one requester at a time by round-robin arbitration. The
// register is loaded, shifted exactly cnt times, and then completion is
// reported with the result and the requester ID.
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   clr      synchronous active-high reset
//   req      request per requester (bit i = requester i)
//   dir      direction per requester: 0 = left (fill enters bit 0),
//            1 = right (fill enters bit WIDTH-1)
//   fill     serial fill bit per requester
//   cnt      shift count per requester, requester i at [i*CNT_W +: CNT_W]
//   data     load word per requester, requester i at [i*WIDTH +: WIDTH]
//   gnt      one-hot one-cycle pulse, job of requester i accepted
//   busy     high from acceptance through the done cycle
//   done     one-cycle pulse, job finished and q valid
//   done_id  requester ID of the last finished job
//   q        register contents, holds the result until the next load
module shift_job_sched #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [1:0]         req,
  input  logic [1:0]         dir,
  input  logic [1:0]         fill,
  input  logic [2*CNT_W-1:0] cnt,
  input  logic [2*WIDTH-1:0] data,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [WIDTH-1:0]   q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               last;
  logic               win;
  logic [CNT_W-1:0]   win_cnt;
  logic [WIDTH-1:0]   win_data;
  logic               job_dir;
  logic               job_fill;
  logic               job_id;
  logic [CNT_W-1:0]   rem;

  // Round-robin pick: a lone request wins outright; on a tie the requester
  // that was not served last wins. last resets to 1 so requester 0 wins the
  // first tie.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~last;
    end else begin
      win = req[1];
    end
    win_cnt  = win ? cnt[CNT_W +: CNT_W] : cnt[0 +: CNT_W];
    win_data = win ? data[WIDTH +: WIDTH] : data[0 +: WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A zero-count job skips SHIFT entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = (win_cnt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (rem == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. The job fields are captured only at
  // acceptance so requester inputs are free to change while the job runs.
  // done is registered on the edge leaving DONE, so it appears in the
  // following IDLE cycle and can never coincide with gnt.
  always_ff @(posedge clk) begin
    if (clr) begin
      q        <= '0;
      gnt      <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      last     <= 1'b1;
      job_dir  <= 1'b0;
      job_fill <= 1'b0;
      job_id   <= 1'b0;
      rem      <= '0;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt      <= win ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            q        <= win_data;
            job_dir  <= dir[win];
            job_fill <= fill[win];
            job_id   <= win;
            rem      <= win_cnt;
            last     <= win;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          if (job_dir) begin
            q <= {job_fill, q[WIDTH-1:1]};
          end else begin
            q <= {q[WIDTH-2:0], job_fill};
          end
          rem <= rem - CNT_W'(1);
        end
        DONE: begin
          done    <= 1'b1;
          done_id <= job_id;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_job_sched.sv
// tb_shift_job_sched
// Directed bench for shift_job_sched (WIDTH=4, CNT_W=3). Inputs are driven
// and outputs sampled on the falling clock edge. Cycle 0 of a job is the
// cycle right after the accepting rising edge; gnt is high there and done
// is high in cycle cnt+1.
module tb_shift_job_sched;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic               clk = 1'b0;
  logic               clr;
  logic [1:0]         req;
  logic [1:0]         dir;
  logic [1:0]         fill;
  logic [2*CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] data;
  logic [1:0]         gnt;
  logic               busy;
  logic               done;
  logic               done_id;
  logic [WIDTH-1:0]   q;

  int checks = 0;
  int errors = 0;

  shift_job_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .req(req), .dir(dir), .fill(fill), .cnt(cnt),
    .data(data), .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .q(q)
  );

  always #5 clk = ~clk;

  // Reset values of every output.
  task automatic test_reset();
    clr = 1'b1; req = 2'b00; dir = 2'b00; fill = 2'b00; cnt = '0; data = '0;
    repeat (2) @(negedge clk);
    checks++; if (q !== 4'b0000) begin errors++; $display("[TB] FAIL reset_q: got %b expected 0000", q); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (done_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_id: got %b expected 0", done_id); end
    clr = 1'b0;
  endtask

  // Requester 0, left shift with fill 1, cnt=2: 0011 -> 0111 -> 1111.
  task automatic test_left_fill1();
    logic [3:0] eq [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    req = 2'b01; dir = 2'b00; fill = 2'b01; cnt = {3'd0, 3'd2}; data = {4'h0, 4'b0011};
    @(negedge clk);
    req = 2'b00;
    for (int c = 0; c < 5; c++) begin
      checks++; if (q !== eq[c]) begin errors++; $display("[TB] FAIL left_q c%0d: got %b expected %b", c, q, eq[c]); end
      checks++; if (gnt !== ((c == 0) ? 2'b01 : 2'b00)) begin errors++; $display("[TB] FAIL left_gnt c%0d: got %b", c, gnt); end
      checks++; if (busy !== (c <= 3)) begin errors++; $display("[TB] FAIL left_busy c%0d: got %b", c, busy); end
      checks++; if (done !== (c == 3)) begin errors++; $display("[TB] FAIL left_done c%0d: got %b", c, done); end
      if (c == 3) begin
        checks++; if (done_id !== 1'b0) begin errors++; $display("[TB] FAIL left_done_id: got %b expected 0", done_id); end
      end
      @(negedge clk);
    end
  endtask

  // Requester 1, right shift with fill 0, cnt=3: 1000 -> 0100 -> 0010 -> 0001.
  task automatic test_right_fill0();
    logic [3:0] eq [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    req = 2'b10; dir = 2'b10; fill = 2'b00; cnt = {3'd3, 3'd0}; data = {4'b1000, 4'h0};
    @(negedge clk);
    req = 2'b00;
    for (int c = 0; c < 6; c++) begin
      checks++; if (q !== eq[c]) begin errors++; $display("[TB] FAIL right_q c%0d: got %b expected %b", c, q, eq[c]); end
      checks++; if (gnt !== ((c == 0) ? 2'b10 : 2'b00)) begin errors++; $display("[TB] FAIL right_gnt c%0d: got %b", c, gnt); end
      checks++; if (busy !== (c <= 4)) begin errors++; $display("[TB] FAIL right_busy c%0d: got %b", c, busy); end
      checks++; if (done !== (c == 4)) begin errors++; $display("[TB] FAIL right_done c%0d: got %b", c, done); end
      if (c == 4) begin
        checks++; if (done_id !== 1'b1) begin errors++; $display("[TB] FAIL right_done_id: got %b expected 1", done_id); end
      end
      @(negedge clk);
    end
  endtask

  // cnt=0 finishes one cycle after gnt with the load word unchanged.
  task automatic test_zero_count();
    req = 2'b01; dir = 2'b00; fill = 2'b01; cnt = {3'd0, 3'd0}; data = {4'h0, 4'b1010};
    @(negedge clk);
    req = 2'b00;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL zero_gnt: got %b expected 01", gnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_early: got %b expected 0", done); end
    checks++; if (q !== 4'b1010) begin errors++; $display("[TB] FAIL zero_q_load: got %b expected 1010", q); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL zero_gnt_off: got %b expected 00", gnt); end
    checks++; if (q !== 4'b1010) begin errors++; $display("[TB] FAIL zero_q_done: got %b expected 1010", q); end
    checks++; if (done_id !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_id: got %b expected 0", done_id); end
    @(negedge clk);
  endtask

  // cnt=7 exceeds WIDTH: left shift with fill 0 flushes 1111 to 0000.
  task automatic test_full_flush();
    logic [3:0] eq [10] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000,
                           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    req = 2'b01; dir = 2'b00; fill = 2'b00; cnt = {3'd0, 3'd7}; data = {4'h0, 4'b1111};
    @(negedge clk);
    req = 2'b00;
    for (int c = 0; c < 10; c++) begin
      checks++; if (q !== eq[c]) begin errors++; $display("[TB] FAIL flush_q c%0d: got %b expected %b", c, q, eq[c]); end
      checks++; if (done !== (c == 8)) begin errors++; $display("[TB] FAIL flush_done c%0d: got %b", c, done); end
      checks++; if (busy !== (c <= 8)) begin errors++; $display("[TB] FAIL flush_busy c%0d: got %b", c, busy); end
      @(negedge clk);
    end
  endtask

  // Both requesters held with cnt=1 after reset: grants alternate 01,10,...
  // Requester 0 shifts 0001 left (fill 0), requester 1 shifts 1000 right (fill 1).
  task automatic test_contention();
    logic [1:0] eg;
    logic [3:0] eq;
    int         job;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; req = 2'b11; dir = 2'b10; fill = 2'b10; cnt = {3'd1, 3'd1};
    data = {4'b1000, 4'b0001};
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      job = (c / 3) % 2;
      eg  = (c % 3 == 0) ? ((job == 0) ? 2'b01 : 2'b10) : 2'b00;
      if (c % 3 == 0) eq = (job == 0) ? 4'b0001 : 4'b1000;
      else            eq = (job == 0) ? 4'b0010 : 4'b1100;
      checks++; if (gnt !== eg) begin errors++; $display("[TB] FAIL cont_gnt c%0d: got %b expected %b", c, gnt, eg); end
      checks++; if (done !== (c % 3 == 2)) begin errors++; $display("[TB] FAIL cont_done c%0d: got %b", c, done); end
      checks++; if (q !== eq) begin errors++; $display("[TB] FAIL cont_q c%0d: got %b expected %b", c, q, eq); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL cont_busy c%0d: got %b expected 1", c, busy); end
      if (c % 3 == 2) begin
        checks++; if (done_id !== job[0]) begin errors++; $display("[TB] FAIL cont_done_id c%0d: got %b expected %0d", c, done_id, job); end
      end
      if (c == 11) req = 2'b00;
      @(negedge clk);
    end
  endtask

  // clr during the second shift of a cnt=5 job drops it and resets the
  // round-robin pointer so the following tie goes to requester 0.
  task automatic test_reset_mid_job();
    req = 2'b01; dir = 2'b00; fill = 2'b01; cnt = {3'd0, 3'd5}; data = {4'h0, 4'b0000};
    @(negedge clk);
    req = 2'b00;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rmid_gnt: got %b expected 01", gnt); end
    @(negedge clk);
    checks++; if (q !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_q_shift1: got %b expected 0001", q); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (q !== 4'b0000) begin errors++; $display("[TB] FAIL rmid_q: got %b expected 0000", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (done_id !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done_id: got %b expected 0", done_id); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done c%0d: got %b expected 0", c, done); end
      @(negedge clk);
    end
    req = 2'b11; cnt = {3'd0, 3'd0}; data = {4'b1100, 4'b0110};
    @(negedge clk);
    req = 2'b00;
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rmid_tie_gnt: got %b expected 01", gnt); end
    checks++; if (q !== 4'b0110) begin errors++; $display("[TB] FAIL rmid_tie_q: got %b expected 0110", q); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rmid_tie_done: got %b expected 1", done); end
    @(negedge clk);
  endtask

  // Requester 1 inputs change after acceptance; the job keeps its latched
  // fields: left, fill 1, cnt 2, 0100 -> 1001 -> 0011.
  task automatic test_input_change();
    logic [3:0] eq [4] = '{4'b0100, 4'b1001, 4'b0011, 4'b0011};
    req = 2'b10; dir = 2'b00; fill = 2'b10; cnt = {3'd2, 3'd0}; data = {4'b0100, 4'h0};
    @(negedge clk);
    req = 2'b00; dir = 2'b11; fill = 2'b00; cnt = {3'd7, 3'd7}; data = {4'b1111, 4'b1111};
    for (int c = 0; c < 4; c++) begin
      checks++; if (q !== eq[c]) begin errors++; $display("[TB] FAIL chg_q c%0d: got %b expected %b", c, q, eq[c]); end
      checks++; if (done !== (c == 3)) begin errors++; $display("[TB] FAIL chg_done c%0d: got %b", c, done); end
      if (c == 3) begin
        checks++; if (done_id !== 1'b1) begin errors++; $display("[TB] FAIL chg_done_id: got %b expected 1", done_id); end
      end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL chg_busy_end: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_left_fill1();
    test_right_fill0();
    test_zero_count();
    test_full_flush();
    test_contention();
    test_reset_mid_job();
    test_input_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
